alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
- Sequential front end that sits directly upstream of the combinational ALU.
- Accepts instructions (opcode, operand, repeat count) over a valid/ready handshake.
- Drives the ALU with an internal accumulator plus operand, then writes the ALU result and flags back each cycle.
- Provides accumulator-style execution, carry chaining through a held carry flag, and multi-cycle repeat (e.g. rotate-by-N).

Parameters:
BUS_WIDTH, 8, datapath width; must match the downstream ALU.
CNT_WIDTH, 4, width of the repeat-count field.

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  instruction valid.
in_ready  out  1  sequencer can accept an instruction.
in_load  in  1  1 = load accumulator with in_operand; no ALU operation.
in_opcode  in  4  ALU opcode: 1 ADD, 2 ADD_CARRY, 3 SUB, 4 INC, 5 DEC, 6 AND, 7 NOT, 8 ROL, 9 ROR.
in_operand  in  BUS_WIDTH  b operand, or load value.
in_count  in  CNT_WIDTH  repeat count; 0 is treated as 1.
alu_a  out  BUS_WIDTH  to ALU a; always equals acc.
alu_b  out  BUS_WIDTH  to ALU b; latched operand.
alu_opcode  out  4  latched opcode during EXEC, else 0.
alu_carry_in  out  1  equals flag_c.
alu_y  in  BUS_WIDTH  ALU result.
alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op  in  1 each  ALU flags.
acc  out  BUS_WIDTH  accumulator.
flag_c, flag_b, flag_z, flag_p  out  1 each  registered carry, borrow, zero and parity.
err  out  1  sticky invalid-opcode flag.
busy  out  1  high in EXEC and DONE.
done  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- Reset (rst_n=0 at a clock edge, including mid-operation):
  - State goes to IDLE.
  - acc=0; all flags=0; err=0; done=0; remaining count=0; latched opcode/operand=0.
  - Any in-flight instruction is discarded with no done pulse.
- States and transitions:
  - IDLE: in_ready=1, busy=0. A transfer happens when in_valid&&in_ready at an edge; it latches opcode, operand and count (0 becomes 1).
    - If in_load: acc<=in_operand, flag_z<=(in_operand==0), flag_p<=^in_operand, flag_c/flag_b unchanged, next state DONE.
    - Otherwise next state EXEC.
  - EXEC: in_ready=0.
    - alu_opcode is the latched opcode; the ALU is purely combinational, so its result is valid in the same cycle.
    - Each cycle, if alu_invalid_op=0: acc<=alu_y, flag_c<=alu_carry_out, flag_b<=alu_borrow, flag_z<=alu_zero, flag_p<=alu_parity, remaining<=remaining-1.
    - Go to DONE when remaining==1; otherwise stay in EXEC.
    - If alu_invalid_op=1: err<=1; acc and flags unchanged; next state DONE (abort remaining iterations).
  - DONE: done=1 for exactly this cycle, in_ready=0, next state IDLE.
- Latency: instruction accepted at edge T; N EXEC cycles follow; done is high in the cycle after edge T+N; in_ready returns the cycle after that.
  - Load: done the cycle after acceptance.
  - Back-to-back throughput is N+2 cycles per instruction.
- Carry chaining: the carry_in used on each repeat is the flag_c captured from the previous iteration or instruction.
- Outside EXEC, alu_opcode=0. The ALU flags invalid_op for that value; the sequencer ignores all ALU inputs outside EXEC.
- in_valid high while busy: no transfer; the upstream source holds the data (standard valid/ready rules, no combinational path from in_valid to in_ready).
- err clears only on reset and does not block later instructions.
- Arithmetic widths are defined by the ALU. The sequencer does no arithmetic apart from the CNT_WIDTH-bit down-counter, which never wraps because it exits at 1.

Test Plan:
1. From reset: load 0xF0, then ADD_CARRY operand 0x20 count 1 -> acc=0x10, flag_c=1, flag_z=0; done exactly 2 cycles after the ADD_CARRY acceptance edge.
2. Load 0x81, then ROL count 3 -> acc sequence 0x03, 0x06, 0x0C over 3 EXEC cycles; busy high 4 cycles; single done pulse.
3. Load 0x00, then DEC count 0 (runs once) -> acc=0xFF, flag_b=1, flag_p=0, flag_z=0.
4. Carry chain: load 0xFF, INC -> acc=0x00, flag_c=1, flag_z=1; then ADD_CARRY operand 0x00 -> acc=0x01, flag_c=0.
5. Opcode 0xA count 5 after load 0x55 -> err=1 after the first EXEC cycle, acc stays 0x55, done the next cycle; a subsequent valid AND keeps err=1.
6. ROL count 8 on 0x01 with rst_n=0 at the 3rd EXEC edge -> next cycle acc=0, in_ready=1, err=0, no done pulse. Separately, in_valid held high during busy is not accepted until IDLE.

Source files
------------

// File: rtl/alu_op_sequencer_if.sv
// Instruction channel between an upstream issuer and alu_op_sequencer.
// An instruction transfers on a rising edge where in_valid && in_ready; while in_valid is high and in_ready is low
// the issuer must hold every field stable, and in_ready never depends combinationally on in_valid.
interface alu_op_sequencer_if #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 4
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 in_load;
    logic [3:0]           in_opcode;
    logic [BUS_WIDTH-1:0] in_operand;
    logic [CNT_WIDTH-1:0] in_count;

    modport master (
        output in_valid,
        output in_load,
        output in_opcode,
        output in_operand,
        output in_count,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_load,
        input  in_opcode,
        input  in_operand,
        input  in_count,
        output in_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Accumulator-style front end for a combinational ALU: accepts one instruction at a time,
// repeats it N times against the accumulator, and keeps registered carry/borrow/zero/parity flags.
module alu_op_sequencer #(
    parameter int BUS_WIDTH = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_op_sequencer_if.slave    in_if,
    output logic [BUS_WIDTH-1:0] alu_a,
    output logic [BUS_WIDTH-1:0] alu_b,
    output logic [3:0]           alu_opcode,
    output logic                 alu_carry_in,
    input  logic [BUS_WIDTH-1:0] alu_y,
    input  logic                 alu_carry_out,
    input  logic                 alu_borrow,
    input  logic                 alu_zero,
    input  logic                 alu_parity,
    input  logic                 alu_invalid_op,
    output logic [BUS_WIDTH-1:0] acc,
    output logic                 flag_c,
    output logic                 flag_b,
    output logic                 flag_z,
    output logic                 flag_p,
    output logic                 err,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [3:0]           op_q;
    logic [BUS_WIDTH-1:0] operand_q;
    logic [CNT_WIDTH-1:0] remaining;
    logic                 accept;
    logic                 exec_step;
    logic                 exec_abort;

    // Next-state and control decode.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        exec_step  = 1'b0;
        exec_abort = 1'b0;
        case (state)
            IDLE: begin
                if (in_if.in_valid) begin
                    accept     = 1'b1;
                    state_next = in_if.in_load ? DONE : EXEC;
                end
            end
            EXEC: begin
                if (alu_invalid_op) begin
                    exec_abort = 1'b1;
                    state_next = DONE;
                end else begin
                    exec_step = 1'b1;
                    if (remaining == CNT_WIDTH'(1)) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            flag_c    <= 1'b0;
            flag_b    <= 1'b0;
            flag_z    <= 1'b0;
            flag_p    <= 1'b0;
            err       <= 1'b0;
            op_q      <= 4'd0;
            operand_q <= '0;
            remaining <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q      <= in_if.in_opcode;
                operand_q <= in_if.in_operand;
                // A zero count still runs the instruction once.
                remaining <= (in_if.in_count == '0) ? CNT_WIDTH'(1) : in_if.in_count;
                if (in_if.in_load) begin
                    acc    <= in_if.in_operand;
                    flag_z <= (in_if.in_operand == '0);
                    flag_p <= ^in_if.in_operand;
                end
            end
            if (exec_step) begin
                acc       <= alu_y;
                flag_c    <= alu_carry_out;
                flag_b    <= alu_borrow;
                flag_z    <= alu_zero;
                flag_p    <= alu_parity;
                remaining <= remaining - CNT_WIDTH'(1);
            end
            if (exec_abort) begin
                err <= 1'b1;
            end
        end
    end

    // The ALU sees opcode 0 outside EXEC, so its outputs are don't-care there.
    assign alu_a        = acc;
    assign alu_b        = operand_q;
    assign alu_opcode   = (state == EXEC) ? op_q : 4'd0;
    assign alu_carry_in = flag_c;

    assign in_if.in_ready = (state == IDLE);
    assign busy           = (state != IDLE);
    assign done           = (state == DONE);
    assign dbg_state      = state;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU attached downstream.
module tb_alu_op_sequencer;

    localparam int BW = 8;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic [BW-1:0] alu_a, alu_b, alu_y, acc;
    logic [3:0]    alu_opcode;
    logic          alu_carry_in, alu_carry_out, alu_borrow, alu_zero, alu_parity, alu_invalid_op;
    logic          flag_c, flag_b, flag_z, flag_p, err, busy, done;
    logic [1:0]    dbg_state;

    int tests_run;
    int tests_failed;

    alu_op_sequencer_if #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) bus ();

    alu_op_sequencer #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_if          (bus.slave),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_opcode     (alu_opcode),
        .alu_carry_in   (alu_carry_in),
        .alu_y          (alu_y),
        .alu_carry_out  (alu_carry_out),
        .alu_borrow     (alu_borrow),
        .alu_zero       (alu_zero),
        .alu_parity     (alu_parity),
        .alu_invalid_op (alu_invalid_op),
        .acc            (acc),
        .flag_c         (flag_c),
        .flag_b         (flag_b),
        .flag_z         (flag_z),
        .flag_p         (flag_p),
        .err            (err),
        .busy           (busy),
        .done           (done),
        .dbg_state      (dbg_state)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream combinational ALU.
    logic [BW:0] wide;
    always_comb begin
        wide           = '0;
        alu_invalid_op = 1'b0;
        alu_carry_out  = 1'b0;
        alu_borrow     = 1'b0;
        case (alu_opcode)
            4'd1: wide = {1'b0, alu_a} + {1'b0, alu_b};
            4'd2: wide = {1'b0, alu_a} + {1'b0, alu_b} + {{BW{1'b0}}, alu_carry_in};
            4'd3: wide = {1'b0, alu_a} - {1'b0, alu_b};
            4'd4: wide = {1'b0, alu_a} + 9'd1;
            4'd5: wide = {1'b0, alu_a} - 9'd1;
            4'd6: wide = {1'b0, alu_a & alu_b};
            4'd7: wide = {1'b0, ~alu_a};
            4'd8: wide = {1'b0, alu_a[BW-2:0], alu_a[BW-1]};
            4'd9: wide = {1'b0, alu_a[0], alu_a[BW-1:1]};
            default: alu_invalid_op = 1'b1;
        endcase
        alu_y = wide[BW-1:0];
        if (alu_opcode == 4'd1 || alu_opcode == 4'd2 || alu_opcode == 4'd4) alu_carry_out = wide[BW];
        if (alu_opcode == 4'd3 || alu_opcode == 4'd5) alu_borrow = wide[BW];
        alu_zero   = (alu_y == '0);
        alu_parity = ^alu_y;
    end

    // Driver: wait for in_ready (bounded), present one instruction, drop valid after the transfer edge.
    task automatic issue(input logic ld, input logic [3:0] op, input logic [BW-1:0] opd, input logic [CW-1:0] cnt);
        int k;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL issue_ready_timeout: in_ready=%b required 1", bus.in_ready);
        end
        bus.in_valid   = 1'b1;
        bus.in_load    = ld;
        bus.in_opcode  = op;
        bus.in_operand = opd;
        bus.in_count   = cnt;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Number of falling edges after the transfer edge up to and including the one where done is high; 0 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_load    = 1'b0;
        bus.in_opcode  = 4'd0;
        bus.in_operand = '0;
        bus.in_count   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({acc, flag_c, flag_b, flag_z, flag_p, err, done, busy} !== {8'h00, 7'b0000000}) begin
            tests_failed++;
            $display("FAIL reset_state: acc=%h c=%b b=%b z=%b p=%b err=%b done=%b busy=%b required all 0",
                     acc, flag_c, flag_b, flag_z, flag_p, err, done, busy);
        end
        tests_run++;
        if (bus.in_ready !== 1'b1 || alu_opcode !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_ready: in_ready=%b alu_opcode=%h required 1 and 0", bus.in_ready, alu_opcode);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_carry();
        int cyc;
        issue(1'b1, 4'd0, 8'hF0, 4'd0);
        wait_done(cyc);
        tests_run++;
        if (cyc !== 1 || acc !== 8'hF0) begin
            tests_failed++;
            $display("FAIL load_latency: cycles=%0d acc=%h required 1 and f0", cyc, acc);
        end
        issue(1'b0, 4'd2, 8'h20, 4'd1);
        wait_done(cyc);
        tests_run++;
        if (cyc !== 2) begin
            tests_failed++;
            $display("FAIL adc_latency: cycles=%0d required 2", cyc);
        end
        tests_run++;
        if (acc !== 8'h10 || flag_c !== 1'b1 || flag_z !== 1'b0) begin
            tests_failed++;
            $display("FAIL adc_result: acc=%h c=%b z=%b required 10 1 0", acc, flag_c, flag_z);
        end
    endtask

    task automatic test_rol_repeat();
        int cyc;
        int busy_cnt;
        int done_cnt;
        logic [BW-1:0] seen [0:5];
        issue(1'b1, 4'd0, 8'h81, 4'd0);
        wait_done(cyc);
        issue(1'b0, 4'd8, 8'h00, 4'd3);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen[i] = acc;
            if (busy) busy_cnt++;
            if (done) done_cnt++;
        end
        tests_run++;
        if (seen[1] !== 8'h03 || seen[2] !== 8'h06 || seen[3] !== 8'h0C) begin
            tests_failed++;
            $display("FAIL rol_sequence: acc=%h,%h,%h required 03,06,0c", seen[1], seen[2], seen[3]);
        end
        tests_run++;
        if (busy_cnt !== 4 || done_cnt !== 1) begin
            tests_failed++;
            $display("FAIL rol_busy_done: busy=%0d done=%0d required 4 and 1", busy_cnt, done_cnt);
        end
    endtask

    task automatic test_dec_count_zero();
        int cyc;
        issue(1'b1, 4'd0, 8'h00, 4'd0);
        wait_done(cyc);
        issue(1'b0, 4'd5, 8'h00, 4'd0);
        wait_done(cyc);
        tests_run++;
        if (cyc !== 2) begin
            tests_failed++;
            $display("FAIL dec_count0_latency: cycles=%0d required 2", cyc);
        end
        tests_run++;
        if (acc !== 8'hFF || flag_b !== 1'b1 || flag_p !== 1'b0 || flag_z !== 1'b0) begin
            tests_failed++;
            $display("FAIL dec_result: acc=%h b=%b p=%b z=%b required ff 1 0 0", acc, flag_b, flag_p, flag_z);
        end
    endtask

    task automatic test_carry_chain();
        int cyc;
        issue(1'b1, 4'd0, 8'hFF, 4'd0);
        wait_done(cyc);
        issue(1'b0, 4'd4, 8'h00, 4'd1);
        wait_done(cyc);
        tests_run++;
        if (acc !== 8'h00 || flag_c !== 1'b1 || flag_z !== 1'b1) begin
            tests_failed++;
            $display("FAIL inc_wrap: acc=%h c=%b z=%b required 00 1 1", acc, flag_c, flag_z);
        end
        issue(1'b0, 4'd2, 8'h00, 4'd1);
        wait_done(cyc);
        tests_run++;
        if (acc !== 8'h01 || flag_c !== 1'b0 || flag_z !== 1'b0) begin
            tests_failed++;
            $display("FAIL carry_chain: acc=%h c=%b z=%b required 01 0 0", acc, flag_c, flag_z);
        end
    endtask

    task automatic test_invalid_op();
        int cyc;
        issue(1'b1, 4'd0, 8'h55, 4'd0);
        wait_done(cyc);
        tests_run++;
        if (err !== 1'b0) begin
            tests_failed++;
            $display("FAIL err_before: err=%b required 0", err);
        end
        issue(1'b0, 4'hA, 8'h00, 4'd5);
        wait_done(cyc);
        tests_run++;
        if (cyc !== 2 || err !== 1'b1 || acc !== 8'h55) begin
            tests_failed++;
            $display("FAIL invalid_abort: cycles=%0d err=%b acc=%h required 2 1 55", cyc, err, acc);
        end
        issue(1'b0, 4'd6, 8'h0F, 4'd1);
        wait_done(cyc);
        tests_run++;
        if (acc !== 8'h05 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL and_after_err: acc=%h err=%b required 05 1", acc, err);
        end
    endtask

    task automatic test_reset_mid_exec();
        int cyc;
        int done_cnt;
        issue(1'b1, 4'd0, 8'h01, 4'd0);
        wait_done(cyc);
        issue(1'b0, 4'd8, 8'h00, 4'd8);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (acc !== 8'h04) begin
            tests_failed++;
            $display("FAIL rol_before_reset: acc=%h required 04", acc);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tests_run++;
        if (acc !== 8'h00 || bus.in_ready !== 1'b1 || err !== 1'b0 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: acc=%h ready=%b err=%b done=%b required 00 1 0 0",
                     acc, bus.in_ready, err, done);
        end
        done_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        tests_run++;
        if (done_cnt !== 0) begin
            tests_failed++;
            $display("FAIL mid_reset_no_done: done pulses=%0d required 0", done_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int k;
        issue(1'b1, 4'd0, 8'h01, 4'd0);
        wait_done(cyc);
        issue(1'b0, 4'd8, 8'h00, 4'd2);
        // Hold a load pending for the whole busy window.
        bus.in_valid   = 1'b1;
        bus.in_load    = 1'b1;
        bus.in_operand = 8'h77;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                k = i;
                break;
            end
        end
        tests_run++;
        if (k !== 4 || acc !== 8'h04) begin
            tests_failed++;
            $display("FAIL held_valid_wait: ready_after=%0d acc=%h required 4 and 04", k, acc);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        wait_done(cyc);
        tests_run++;
        if (cyc !== 1 || acc !== 8'h77) begin
            tests_failed++;
            $display("FAIL held_valid_accept: cycles=%0d acc=%h required 1 and 77", cyc, acc);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_add_carry();
        test_rol_repeat();
        test_dec_count_zero();
        test_carry_chain();
        test_invalid_op();
        test_reset_mid_exec();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
